// File: rtl/cfi_alert_ctrl.sv
// CFI alert policy: turns per-port NOP/JALR commit flags into one sticky, acknowledged
// alert (NOP-sled run length and JALR burst per time window), with a post-ack cooldown.
module cfi_alert_ctrl #(
    parameter int NR_COMMIT_PORTS = 2,
    parameter int SLED_CNT_W      = 8,
    parameter int SLED_THRESH     = 16,
    parameter int WIN_W           = 8,
    parameter int JALR_WINDOW     = 64,
    parameter int JALR_MAX        = 8,
    parameter int COOLDOWN        = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NR_COMMIT_PORTS-1:0] commit_ack_i,
    input  logic [NR_COMMIT_PORTS-1:0] jalr_det_i,
    input  logic [NR_COMMIT_PORTS-1:0] nop_det_i,
    input  logic                       alert_ack_i,
    output logic                       alert_o,
    output logic [1:0]                 alert_cause_o,
    output logic [SLED_CNT_W-1:0]      sled_len_o,
    output logic [WIN_W-1:0]           jalr_cnt_o
);

    typedef enum logic [1:0] {IDLE, ALERT, COOL} state_e;

    localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam logic [WIN_W-1:0]    WIN_LAST  = WIN_W'(JALR_WINDOW - 1);
    localparam logic [SLED_CNT_W:0] SLED_TH   = (SLED_CNT_W+1)'(SLED_THRESH);
    localparam logic [WIN_W:0]      JALR_LIM  = (WIN_W+1)'(JALR_MAX);
    localparam logic [CW-1:0]       COOL_INIT = CW'(COOLDOWN - 1);

    state_e                  state_q, state_d;
    logic [SLED_CNT_W-1:0]   sled_q, sled_d, sled_nxt;
    logic [WIN_W-1:0]        win_q, win_d, win_nxt;
    logic [WIN_W-1:0]        jalr_q, jalr_d, jalr_nxt;
    logic [1:0]              cause_q, cause_d;
    logic [CW-1:0]           cool_q, cool_d;
    logic [WIN_W:0]          jalr_pc;
    logic                    win_wrap;
    logic                    sled_hit;
    logic                    jalr_hit;

    function automatic logic [SLED_CNT_W-1:0] sled_inc(input logic [SLED_CNT_W-1:0] cnt);
        return (cnt == {SLED_CNT_W{1'b1}}) ? cnt : cnt + SLED_CNT_W'(1);
    endfunction

    function automatic logic [WIN_W-1:0] jalr_sat(input logic [WIN_W:0] sum);
        return sum[WIN_W] ? {WIN_W{1'b1}} : sum[WIN_W-1:0];
    endfunction

    // Ports are applied in ascending order, so a non-NOP on a lower port breaks the run
    // before a NOP on a higher port restarts it.
    always_comb begin
        sled_nxt = sled_q;
        jalr_pc  = '0;
        for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
            if (commit_ack_i[p]) begin
                sled_nxt = nop_det_i[p] ? sled_inc(sled_nxt) : '0;
            end
            jalr_pc = jalr_pc + (WIN_W+1)'(commit_ack_i[p] & jalr_det_i[p]);
        end
        win_wrap = (win_q == WIN_LAST);
        win_nxt  = win_wrap ? '0 : win_q + WIN_W'(1);
        jalr_nxt = win_wrap ? jalr_sat(jalr_pc) : jalr_sat({1'b0, jalr_q} + jalr_pc);
        sled_hit = ({1'b0, sled_nxt} >= SLED_TH);
        jalr_hit = ({1'b0, jalr_nxt} > JALR_LIM);
    end

    always_comb begin
        state_d = state_q;
        sled_d  = sled_nxt;
        win_d   = win_nxt;
        jalr_d  = jalr_nxt;
        cause_d = cause_q;
        cool_d  = cool_q;
        unique case (state_q)
            IDLE: begin
                if (sled_hit || jalr_hit) begin
                    state_d = ALERT;
                    cause_d = {jalr_hit, sled_hit};
                end
            end
            ALERT: begin
                // An ack drops any hit arriving in the same cycle.
                if (alert_ack_i) begin
                    state_d = COOL;
                    cause_d = '0;
                    sled_d  = '0;
                    win_d   = '0;
                    jalr_d  = '0;
                    cool_d  = COOL_INIT;
                end else begin
                    cause_d = cause_q | {jalr_hit, sled_hit};
                end
            end
            COOL: begin
                sled_d = '0;
                win_d  = '0;
                jalr_d = '0;
                if (cool_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cool_d = cool_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sled_q  <= '0;
            win_q   <= '0;
            jalr_q  <= '0;
            cause_q <= '0;
            cool_q  <= '0;
        end else begin
            state_q <= state_d;
            sled_q  <= sled_d;
            win_q   <= win_d;
            jalr_q  <= jalr_d;
            cause_q <= cause_d;
            cool_q  <= cool_d;
        end
    end

    assign alert_o       = (state_q == ALERT);
    assign alert_cause_o = cause_q;
    assign sled_len_o    = sled_q;
    assign jalr_cnt_o    = jalr_q;

endmodule
